// File: rtl/ex_iter_pkg.sv
// Shared definitions for the iterative execute unit: op codes, CCR bit
// positions, jump condition codes and the control state encoding.
package ex_iter_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  // CCR layout {OVF,Z,N,C}
  localparam int F_C   = 0;
  localparam int F_N   = 1;
  localparam int F_Z   = 2;
  localparam int F_OVF = 3;

  localparam logic [1:0] J_ALW = 2'd0;
  localparam logic [1:0] J_C   = 2'd1;
  localparam logic [1:0] J_N   = 2'd2;
  localparam logic [1:0] J_Z   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // Jump condition against the CCR value seen at the accepting edge
  function automatic logic jmp_cond(input logic [1:0] sel, input logic [3:0] f);
    case (sel)
      J_C:     return f[F_C];
      J_N:     return f[F_N];
      J_Z:     return f[F_Z];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Shared shift-register datapath for unsigned shift-add multiply and
// restoring divide. One iteration per step; {hi,lo} holds the product, or
// remainder/quotient, after WIDTH steps.
module iter_muldiv
  import ex_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic             div_mode;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_diff;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Candidate next values for one multiply or divide iteration
  always_comb begin
    add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted  = {hi, lo[WIDTH-1]};
    sub_diff = shifted - {1'b0, opnd};
  end

  // Iteration counter and mode; the only reset state in this datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      div_mode <= load_div;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shift register: multiply shifts right through hi:lo, divide shifts left
  always_ff @(posedge clk) begin
    if (load) begin
      hi   <= '0;
      lo   <= load_div ? a : b;
      opnd <= load_div ? b : a;
    end else if (step) begin
      if (div_mode) begin
        // bit WIDTH of the difference is the borrow: restore on borrow
        if (!sub_diff[WIDTH]) begin
          hi <= sub_diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= shifted[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= add_sum[WIDTH:1];
        lo <= {add_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_iter.sv
// Execute stage: single-cycle ALU ops, iterative MUL/DIV through
// iter_muldiv, condition-code register and jump resolution, with a
// valid/ready output register towards EX_MEM.
module ex_iter
  import ex_iter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rdst_val,
  input  logic [WIDTH-1:0] rsrc_val,
  input  logic [PC_W-1:0]  pc,
  input  logic             jmp_en,
  input  logic [1:0]       jmp_sel,
  input  logic [3:0]       flag_upd,
  input  logic             pop_en,
  input  logic [3:0]       pop_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags,
  output logic             div_zero,
  output logic             do_jmp,
  output logic [PC_W-1:0]  jmp_addr
);

  state_t state;

  logic accept, is_mul, is_div, iter_op, taken;
  logic signed [WIDTH-1:0] disp;
  logic signed [PC_W-1:0]  disp_ext;
  logic [PC_W-1:0]  jaddr;
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_lo;
  logic [3:0]       alu_fval;

  logic             ld_out, ld_dz, ld_jmp;
  logic [WIDTH-1:0] ld_lo, ld_hi;
  logic [PC_W-1:0]  ld_jaddr;
  logic [3:0]       ld_fval, ld_fupd, flags_nxt;

  logic             pend_mul, pend_dz;
  logic [3:0]       pend_fupd;
  logic [PC_W-1:0]  pend_jaddr;

  logic [WIDTH-1:0] dp_hi, dp_lo;
  logic             dp_last, dp_step;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);
  assign is_div   = (op == OP_DIV);
  assign iter_op  = is_mul || is_div;
  assign taken    = accept && jmp_en && jmp_cond(jmp_sel, flags);
  assign dp_step  = (state == S_MUL) || (state == S_DIV);

  // Jump target: pc plus sign-extended displacement, wrapping at PC_W bits
  always_comb begin
    disp     = signed'(rdst_val);
    disp_ext = PC_W'(disp);
    jaddr    = pc + $unsigned(disp_ext);
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && iter_op),
    .load_div (is_div),
    .step     (dp_step),
    .a        (rdst_val),
    .b        (rsrc_val),
    .hi       (dp_hi),
    .lo       (dp_lo),
    .last     (dp_last)
  );

  // Single-cycle ALU result and its candidate flag values
  always_comb begin
    alu_sum  = '0;
    alu_lo   = '0;
    alu_fval = flags;
    case (op)
      OP_ADD: begin
        alu_sum         = {1'b0, rdst_val} + {1'b0, rsrc_val};
        alu_lo          = alu_sum[WIDTH-1:0];
        alu_fval[F_C]   = alu_sum[WIDTH];
        alu_fval[F_OVF] = (rdst_val[WIDTH-1] == rsrc_val[WIDTH-1]) &&
                          (alu_lo[WIDTH-1] != rdst_val[WIDTH-1]);
      end
      OP_SUB: begin
        alu_sum         = {1'b0, rdst_val} - {1'b0, rsrc_val};
        alu_lo          = alu_sum[WIDTH-1:0];
        alu_fval[F_C]   = alu_sum[WIDTH];
        alu_fval[F_OVF] = (rdst_val[WIDTH-1] != rsrc_val[WIDTH-1]) &&
                          (alu_lo[WIDTH-1] != rdst_val[WIDTH-1]);
      end
      OP_INC: begin
        alu_sum         = {1'b0, rdst_val} + (WIDTH+1)'(1);
        alu_lo          = alu_sum[WIDTH-1:0];
        alu_fval[F_C]   = alu_sum[WIDTH];
        alu_fval[F_OVF] = !rdst_val[WIDTH-1] && alu_lo[WIDTH-1];
      end
      OP_AND:  alu_lo = rdst_val & rsrc_val;
      OP_OR:   alu_lo = rdst_val | rsrc_val;
      OP_NOT:  alu_lo = ~rdst_val;
      OP_SHL:  alu_lo = rdst_val << rsrc_val[3:0];
      OP_SHR:  alu_lo = rdst_val >> rsrc_val[3:0];
      OP_MOV:  alu_lo = rsrc_val;
      default: alu_lo = '0;
    endcase
    alu_fval[F_Z] = (alu_lo == '0);
    alu_fval[F_N] = alu_lo[WIDTH-1];
  end

  // Select what loads into the output register: ALU at accept, or the
  // finished MUL/DIV in DONE
  always_comb begin
    ld_out   = 1'b0;
    ld_lo    = alu_lo;
    ld_hi    = '0;
    ld_dz    = 1'b0;
    ld_jmp   = taken;
    ld_jaddr = jaddr;
    ld_fval  = alu_fval;
    ld_fupd  = flag_upd;
    if (state == S_DONE) begin
      ld_out   = 1'b1;
      ld_jmp   = 1'b0;
      ld_jaddr = pend_jaddr;
      ld_fupd  = pend_fupd;
      ld_fval  = flags;
      if (pend_dz) begin
        ld_lo   = '1;
        ld_hi   = dp_lo;
        ld_dz   = 1'b1;
        ld_fupd = '0;
      end else begin
        ld_lo = dp_lo;
        ld_hi = dp_hi;
        ld_fval[F_Z] = pend_mul ? ({dp_hi, dp_lo} == '0) : (dp_lo == '0);
        ld_fval[F_N] = pend_mul ? dp_hi[WIDTH-1] : dp_lo[WIDTH-1];
      end
    end else if (accept && !iter_op) begin
      ld_out = 1'b1;
    end
  end

  // Next CCR from result flags then the taken-jump clear (pop overrides later)
  always_comb begin
    flags_nxt = flags;
    if (ld_out) flags_nxt = (flags & ~ld_fupd) | (ld_fval & ld_fupd);
    if (taken) begin
      case (jmp_sel)
        J_C:     flags_nxt[F_C] = 1'b0;
        J_N:     flags_nxt[F_N] = 1'b0;
        J_Z:     flags_nxt[F_Z] = 1'b0;
        default: ;
      endcase
    end
  end

  // Condition-code register; a MEM-stage pop wins over everything but reset
  always_ff @(posedge clk) begin
    if (!reset)      flags <= '0;
    else if (pop_en) flags <= pop_flags;
    else             flags <= flags_nxt;
  end

  // Control FSM and the output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      pend_mul  <= 1'b0;
      pend_dz   <= 1'b0;
      out_valid <= 1'b0;
      res_lo    <= '0;
      res_hi    <= '0;
      div_zero  <= 1'b0;
      do_jmp    <= 1'b0;
      jmp_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mul)      state <= S_MUL;
          else if (accept && is_div) state <= (rsrc_val == '0) ? S_DONE : S_DIV;
        end
        S_MUL, S_DIV: if (dp_last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (accept && iter_op) begin
        pend_mul <= is_mul;
        pend_dz  <= is_div && (rsrc_val == '0);
      end
      if (ld_out) begin
        out_valid <= 1'b1;
        res_lo    <= ld_lo;
        res_hi    <= ld_hi;
        div_zero  <= ld_dz;
        do_jmp    <= ld_jmp;
        jmp_addr  <= ld_jaddr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        res_lo    <= '0;
        res_hi    <= '0;
        div_zero  <= 1'b0;
        do_jmp    <= 1'b0;
        jmp_addr  <= '0;
      end
    end
  end

  // Side information for an in-flight MUL/DIV, consumed in DONE
  always_ff @(posedge clk) begin
    if (accept && iter_op) begin
      pend_fupd  <= flag_upd;
      pend_jaddr <= jaddr;
    end
  end

endmodule

// File: tb/tb_ex_iter.sv
// Directed bench for ex_iter: results are predicted into a scoreboard at
// issue time and compared when the output register hands them over.
module tb_ex_iter;
  import ex_iter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] rdst_val, rsrc_val;
  logic [31:0] pc;
  logic        jmp_en;
  logic [1:0]  jmp_sel;
  logic [3:0]  flag_upd;
  logic        pop_en;
  logic [3:0]  pop_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res_lo, res_hi;
  logic [3:0]  flags;
  logic        div_zero, do_jmp;
  logic [31:0] jmp_addr;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    logic        jmp;
    logic [31:0] ja;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  ex_iter #(.WIDTH(16), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rdst_val(rdst_val), .rsrc_val(rsrc_val), .pc(pc),
    .jmp_en(jmp_en), .jmp_sel(jmp_sel), .flag_upd(flag_upd),
    .pop_en(pop_en), .pop_flags(pop_flags), .out_valid(out_valid),
    .out_ready(out_ready), .res_lo(res_lo), .res_hi(res_hi), .flags(flags),
    .div_zero(div_zero), .do_jmp(do_jmp), .jmp_addr(jmp_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Scoreboard: every handed-over result must match the oldest prediction
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      check("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("sb_res_lo",   64'(res_lo),   64'(e.lo));
        check("sb_res_hi",   64'(res_hi),   64'(e.hi));
        check("sb_div_zero", 64'(div_zero), 64'(e.dz));
        check("sb_do_jmp",   64'(do_jmp),   64'(e.jmp));
        check("sb_jmp_addr", 64'(jmp_addr), 64'(e.ja));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] o, input logic [15:0] rd, input logic [15:0] rs,
                       input logic [3:0] fu, input logic je, input logic [1:0] js,
                       input logic [31:0] p, input logic pe, input logic [3:0] pf,
                       input bit push, input logic [15:0] elo, input logic [15:0] ehi,
                       input logic edz, input logic ejmp);
    int   n = 0;
    exp_t e;
    op = o; rdst_val = rd; rsrc_val = rs; flag_upd = fu;
    jmp_en = je; jmp_sel = js; pc = p; pop_en = pe; pop_flags = pf;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("issue_ready", 64'(n < 100), 64'd1);
    if (push) begin
      e.lo = elo; e.hi = ehi; e.dz = edz; e.jmp = ejmp; e.ja = p + sext16(rd);
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; pop_en = 1'b0; jmp_en = 1'b0;
  endtask

  // Wait for out_valid; optionally require in_ready low while busy
  task automatic drain(input bit chk_busy, output int k);
    k = 0;
    do begin
      @(negedge clk); k++;
      if (chk_busy && !out_valid) check("busy_in_ready", 64'(in_ready), 64'd0);
    end while (!out_valid && k < 100);
    check("drain_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic alu(input string tag, input logic [3:0] o, input logic [15:0] rd,
                     input logic [15:0] rs, input logic [3:0] fu,
                     input logic [15:0] elo, input logic [3:0] eflags);
    int k;
    issue(o, rd, rs, fu, 1'b0, J_ALW, 32'h0, 1'b0, 4'h0, 1'b1, elo, 16'h0, 1'b0, 1'b0);
    drain(1'b0, k);
    check({tag, "_lat"}, 64'(k), 64'd1);
    check({tag, "_flags"}, 64'(flags), 64'(eflags));
    @(posedge clk); #1;
  endtask

  task automatic pop(input logic [3:0] pf);
    pop_en = 1'b1; pop_flags = pf;
    @(posedge clk); #1;
    pop_en = 1'b0;
    check("pop_flags", 64'(flags), 64'(pf));
  endtask

  initial begin
    int  k;
    bit  saw;
    reset = 1'b0; in_valid = 1'b0; op = 4'h0; rdst_val = 16'h0; rsrc_val = 16'h0;
    pc = 32'h0; jmp_en = 1'b0; jmp_sel = 2'd0; flag_upd = 4'h0;
    pop_en = 1'b0; pop_flags = 4'h0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res_lo",    64'(res_lo),    64'd0);
    check("rst_res_hi",    64'(res_hi),    64'd0);
    check("rst_flags",     64'(flags),     64'd0);
    check("rst_div_zero",  64'(div_zero),  64'd0);
    check("rst_do_jmp",    64'(do_jmp),    64'd0);
    check("rst_jmp_addr",  64'(jmp_addr),  64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // single-cycle ops: {OVF,Z,N,C}
    alu("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 4'hF, 16'h8000, 4'hA);
    alu("sub_brw", OP_SUB, 16'h0003, 16'h0005, 4'hF, 16'hFFFE, 4'h3);
    alu("and_z",   OP_AND, 16'hF0F0, 16'h0F0F, 4'hF, 16'h0000, 4'h5);
    alu("or",      OP_OR,  16'h00F0, 16'h0F00, 4'h0, 16'h0FF0, 4'h5);
    alu("not",     OP_NOT, 16'h00FF, 16'h1111, 4'h0, 16'hFF00, 4'h5);
    alu("shl",     OP_SHL, 16'h0001, 16'h0013, 4'h0, 16'h0008, 4'h5);
    alu("shr",     OP_SHR, 16'h8000, 16'h0004, 4'h0, 16'h0800, 4'h5);
    alu("inc_ovf", OP_INC, 16'h7FFF, 16'h0000, 4'hF, 16'h8000, 4'hA);
    alu("mov",     OP_MOV, 16'h0000, 16'h1234, 4'hF, 16'h1234, 4'h8);
    alu("op12",    4'd12,  16'h5555, 16'hAAAA, 4'hF, 16'h0000, 4'hC);

    // MUL 0xFFFF*0xFFFF
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 4'hF, 1'b0, J_ALW, 32'h0, 1'b0, 4'h0,
          1'b1, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    drain(1'b1, k);
    check("mul_lat",   64'(k),     64'd18);
    check("mul_flags", 64'(flags), 64'hA);
    @(posedge clk); #1;

    // DIV by zero: short path, flags untouched
    issue(OP_DIV, 16'd100, 16'd0, 4'hF, 1'b0, J_ALW, 32'h0, 1'b0, 4'h0,
          1'b1, 16'hFFFF, 16'd100, 1'b1, 1'b0);
    drain(1'b1, k);
    check("div0_lat",   64'(k),     64'd2);
    check("div0_flags", 64'(flags), 64'hA);
    @(posedge clk); #1;

    issue(OP_DIV, 16'd100, 16'd7, 4'h0, 1'b0, J_ALW, 32'h0, 1'b0, 4'h0,
          1'b1, 16'd14, 16'd2, 1'b0, 1'b0);
    drain(1'b1, k);
    check("div_lat",   64'(k),     64'd18);
    check("div_flags", 64'(flags), 64'hA);
    @(posedge clk); #1;

    // taken JC clears C
    pop(4'b0001);
    issue(OP_NOP, 16'hFFF0, 16'h0, 4'h0, 1'b1, J_C, 32'h10, 1'b0, 4'h0,
          1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
    check("jc_clear_c", 64'(flags), 64'h0);
    drain(1'b0, k);
    @(posedge clk); #1;

    // same-edge pop wins over the jump clear
    pop(4'b0001);
    issue(OP_NOP, 16'hFFF0, 16'h0, 4'h0, 1'b1, J_C, 32'h10, 1'b1, 4'b0001,
          1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
    check("jc_pop_wins", 64'(flags), 64'h1);
    drain(1'b0, k);
    @(posedge clk); #1;

    // JZ not taken (Z=0), result still carried
    issue(OP_MOV, 16'h0004, 16'h0055, 4'h0, 1'b1, J_Z, 32'h100, 1'b0, 4'h0,
          1'b1, 16'h0055, 16'h0, 1'b0, 1'b0);
    drain(1'b0, k);
    check("jz_flags", 64'(flags), 64'h1);
    @(posedge clk); #1;

    // output held under back-pressure
    out_ready = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0002, 4'h0, 1'b0, J_ALW, 32'h0, 1'b0, 4'h0,
          1'b1, 16'h0003, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid",    64'(out_valid), 64'd1);
      check("hold_res_lo",   64'(res_lo),    64'h3);
      check("hold_in_ready", 64'(in_ready),  64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_cleared", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // reset in the middle of a DIV abandons it
    issue(OP_DIV, 16'd1000, 16'd3, 4'hF, 1'b0, J_ALW, 32'h0, 1'b0, 4'h0,
          1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_flags",    64'(flags),     64'd0);
    check("mid_rst_in_ready", 64'(in_ready),  64'd1);
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    check("mid_rst_no_out", 64'(saw),      64'd0);
    check("sb_drained",     64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
